parking_access_ctrl: RTL and testbench
======================================

// Module: parking_access_ctrl
// PURPOSE
// Transaction controller that drives the ID/floor database block. It consumes the database's verdict flags
// (id_valid, id_special, adminId_valid, id_exists, id_restricted) and decides each request. It then
// issues the one-cycle action_taken command and owns the free-slot counters fed back as remain_flr_*.
// Sits between the keypad/ID front end and the ID database, one transaction at a time.
// PARAMETERS
// CAP_SPEC_0   3'd2   capacity of special area, floor 0 (reset value of remain_flr_spec_0)
// CAP_NORM_0   3'd5   capacity of normal area, floor 0
// CAP_1        3'd7   capacity of floor 1
// ALT_TIMEOUT  16     cycles to wait for user reply to an alternative-floor offer (>=2)
// PORTS
// CLK                in   1  system clock, all state on posedge
// RST                in   1  asynchronous, active-high reset
// id_submit          in   1  one-cycle strobe: ID/MODE/chosen_flr presented; ignored while busy
// MODE               in   2  0 enter, 1 exit, 2 restrict, 3 unrestrict
// chosen_flr         in   1  requested floor (0/1)
// alt_accept         in   1  user accepts offered alternative floor (pulse)
// alt_decline        in   1  user declines offered alternative floor (pulse)
// id_valid,id_special,adminId_valid,id_exists,id_restricted  in 1 each  verdict flags from ID database
// user_flr           in   1  floor the exiting normal user occupies
// action_taken       out  3  0 none,1 alt floor,2 chosen floor,3 exit,4 restrict,5 unrestrict
// remain_flr_spec_0  out  3  free special slots floor 0
// remain_flr_norm_0  out  3  free normal slots floor 0
// remain_flr_1       out  3  free slots floor 1
// status             out  3  0 idle,1 granted,2 denied,3 alt offered,4 full,5 admin ok,6 admin wait
// busy               out  1  high in every state except IDLE
// BEHAVIOUR
// - Reset: state IDLE, action_taken=0, status=0, busy=0, remain_* = CAP_*, timeout counter 0.
// - FSM: IDLE -> EVAL (on id_submit) -> ISSUE | ALT_WAIT | ADMIN_WAIT | DONE; ISSUE -> DONE; DONE -> IDLE.
// - ID, MODE and chosen_flr are held stable by the front end while busy=1; flags are evaluated in EVAL.
// - EVAL, MODE=0 with id_special: if remain_flr_spec_0>0, go ISSUE with action 2, else status=4, go DONE.
// - EVAL, MODE=0 with id_valid: if the chosen floor is not full, go ISSUE with action 2.
//   If the chosen floor is full but the alternative is not: status=3, go ALT_WAIT.
//   If both floors are full: status=4, go DONE.
// - EVAL, MODE=0 with neither flag: status=2, go DONE.
// - ALT_WAIT: alt_accept goes ISSUE with action 1. alt_decline, or ALT_TIMEOUT cycles elapsing, sets
//   status=2 and goes DONE. If both alt pulses arrive in the same cycle, accept wins. The counter
//   clears on entry.
// - EVAL, MODE=1: id_special or id_valid goes ISSUE with action 3; otherwise status=2, go DONE.
// - EVAL, MODE=2/3 (step 1): adminId_valid sets status=6 and goes ADMIN_WAIT; otherwise status=2, go DONE.
// - ADMIN_WAIT: the next id_submit (target ID) with id_exists goes ISSUE with action 4 (MODE=2) or
//   5 (MODE=3). Without id_exists: status=2, go DONE. ALT_TIMEOUT applies here as well.
// - ISSUE: action_taken is nonzero for exactly this one cycle and 0 in every other state.
//   status=1 for actions 1-3, status=5 for actions 4-5.
// - Counter updates, registered at the end of ISSUE:
//   action 2 or 1 decrements the target floor's counter (special -> spec_0).
//   action 3 increments spec_0 for special users, else the counter of user_flr.
// - Counters saturate: never below 0, never above CAP_*. Out-of-range increments and decrements are dropped.
// - Full tests: floor 0 full = remain_flr_norm_0==0; floor 1 full = remain_flr_1==0; alternative = !chosen_flr.
// - DONE: one cycle, busy=1. status holds its value through IDLE until the next accepted id_submit.
// - Asserting RST in any state aborts the transaction immediately, with no partial counter update.
// TESTING
// - Reset, then enter normal user chosen_flr=1 with id_valid=1: action_taken=2 for 1 cycle, remain_flr_1 7->6, status=1.
// - Floor 0 full (norm_0=0), floor 1 free: enter with chosen_flr=0 -> status=3; alt_accept -> action 1, remain_flr_1 -1.
// - Both floors full, enter: status=4, action_taken stays 0, counters unchanged; in ALT_WAIT, no reply for 16 cycles -> status=2.
// - Special user with spec_0=2: two enters -> action 2 each, spec_0=0; third enter -> status=4; exit -> action 3, spec_0=1.
// - MODE=2: admin ID, then target with id_exists=1 -> action 4 for 1 cycle, status=5; non-admin first ID -> status=2.
// - Exit at full capacity (remain=CAP) saturates with no wrap; RST asserted in ALT_WAIT -> IDLE, busy=0, counters unchanged.

Source files
------------

// File: rtl/parking_access_ctrl.sv
// Parking access transaction controller: evaluates ID database verdicts, issues one-cycle
// action commands and maintains saturating free-slot counters for each floor area.
module parking_access_ctrl #(
  parameter logic [2:0]  CAP_SPEC_0  = 3'd2,
  parameter logic [2:0]  CAP_NORM_0  = 3'd5,
  parameter logic [2:0]  CAP_1       = 3'd7,
  parameter int unsigned ALT_TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       id_submit,
  input  logic [1:0] MODE,
  input  logic       chosen_flr,
  input  logic       alt_accept,
  input  logic       alt_decline,
  input  logic       id_valid,
  input  logic       id_special,
  input  logic       adminId_valid,
  input  logic       id_exists,
  input  logic       id_restricted,
  input  logic       user_flr,
  output logic [2:0] action_taken,
  output logic [2:0] remain_flr_spec_0,
  output logic [2:0] remain_flr_norm_0,
  output logic [2:0] remain_flr_1,
  output logic [2:0] status,
  output logic       busy
);

  localparam int unsigned TW = (ALT_TIMEOUT > 2) ? $clog2(ALT_TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, EVAL, ISSUE, ALT_WAIT, ADMIN_WAIT, DONE} state_e;
  typedef enum logic [1:0] {T_SPEC, T_NORM0, T_FLR1} tgt_e;

  state_e        state;
  tgt_e          tgt;
  logic [1:0]    mode_q;
  logic          flr_q;
  logic [TW-1:0] tcnt;

  // Restriction status is enforced by the database itself; this block does not act on it.
  logic unused_flags;
  assign unused_flags = id_restricted;

  logic flr0_full, flr1_full, chosen_full, alt_full, is_inc, is_dec, tmo;
  always_comb begin
    flr0_full   = (remain_flr_norm_0 == '0);
    flr1_full   = (remain_flr_1 == '0);
    chosen_full = flr_q ? flr1_full : flr0_full;
    alt_full    = flr_q ? flr0_full : flr1_full;
    is_inc      = (action_taken == 3'd3);
    is_dec      = (action_taken == 3'd1) || (action_taken == 3'd2);
    tmo         = (tcnt == TW'(ALT_TIMEOUT - 1));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= IDLE;
      tgt               <= T_SPEC;
      mode_q            <= '0;
      flr_q             <= 1'b0;
      tcnt              <= '0;
      action_taken      <= '0;
      status            <= '0;
      busy              <= 1'b0;
      remain_flr_spec_0 <= CAP_SPEC_0;
      remain_flr_norm_0 <= CAP_NORM_0;
      remain_flr_1      <= CAP_1;
    end else begin
      // action_taken is only ever loaded on the transition into ISSUE, so it is a one-cycle pulse
      action_taken <= '0;
      case (state)
        IDLE: if (id_submit) begin
          state  <= EVAL;
          busy   <= 1'b1;
          status <= '0;
          mode_q <= MODE;
          flr_q  <= chosen_flr;
        end
        EVAL: begin
          state  <= DONE;
          status <= 3'd2;
          case (mode_q)
            2'd0: begin
              if (id_special) begin
                if (remain_flr_spec_0 != '0) begin
                  state <= ISSUE; action_taken <= 3'd2; status <= 3'd1; tgt <= T_SPEC;
                end else status <= 3'd4;
              end else if (id_valid) begin
                if (!chosen_full) begin
                  state <= ISSUE; action_taken <= 3'd2; status <= 3'd1;
                  tgt   <= flr_q ? T_FLR1 : T_NORM0;
                end else if (!alt_full) begin
                  state <= ALT_WAIT; status <= 3'd3; tcnt <= '0;
                end else status <= 3'd4;
              end
            end
            2'd1: begin
              if (id_special || id_valid) begin
                state <= ISSUE; action_taken <= 3'd3; status <= 3'd1;
                tgt   <= id_special ? T_SPEC : (user_flr ? T_FLR1 : T_NORM0);
              end
            end
            default: begin
              if (adminId_valid) begin
                state <= ADMIN_WAIT; status <= 3'd6; tcnt <= '0;
              end
            end
          endcase
        end
        ISSUE: begin
          state <= DONE;
          case (tgt)
            T_SPEC: begin
              if (is_inc && remain_flr_spec_0 != CAP_SPEC_0) remain_flr_spec_0 <= remain_flr_spec_0 + 3'd1;
              else if (is_dec && remain_flr_spec_0 != '0)    remain_flr_spec_0 <= remain_flr_spec_0 - 3'd1;
            end
            T_NORM0: begin
              if (is_inc && remain_flr_norm_0 != CAP_NORM_0) remain_flr_norm_0 <= remain_flr_norm_0 + 3'd1;
              else if (is_dec && remain_flr_norm_0 != '0)    remain_flr_norm_0 <= remain_flr_norm_0 - 3'd1;
            end
            default: begin
              if (is_inc && remain_flr_1 != CAP_1)      remain_flr_1 <= remain_flr_1 + 3'd1;
              else if (is_dec && remain_flr_1 != '0)    remain_flr_1 <= remain_flr_1 - 3'd1;
            end
          endcase
        end
        ALT_WAIT: begin
          if (alt_accept) begin
            state <= ISSUE; action_taken <= 3'd1; status <= 3'd1;
            tgt   <= flr_q ? T_NORM0 : T_FLR1;
          end else if (alt_decline || tmo) begin
            state <= DONE; status <= 3'd2;
          end else tcnt <= tcnt + TW'(1);
        end
        ADMIN_WAIT: begin
          if (id_submit) begin
            if (id_exists) begin
              state <= ISSUE; status <= 3'd5;
              action_taken <= (mode_q == 2'd2) ? 3'd4 : 3'd5;
            end else begin
              state <= DONE; status <= 3'd2;
            end
          end else if (tmo) begin
            state <= DONE; status <= 3'd2;
          end else tcnt <= tcnt + TW'(1);
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_access_ctrl.sv
// Self-checking bench for parking_access_ctrl: expected transaction results are queued
// before each transaction is driven and compared once the controller returns to idle.
module tb_parking_access_ctrl;

  logic       CLK = 1'b0, RST = 1'b1, id_submit = 1'b0;
  logic [1:0] MODE = '0;
  logic       chosen_flr = 1'b0, alt_accept = 1'b0, alt_decline = 1'b0;
  logic       id_valid = 1'b0, id_special = 1'b0, adminId_valid = 1'b0;
  logic       id_exists = 1'b0, id_restricted = 1'b0, user_flr = 1'b0;
  logic [2:0] action_taken, remain_flr_spec_0, remain_flr_norm_0, remain_flr_1, status;
  logic       busy;

  parking_access_ctrl #(.CAP_SPEC_0(3'd2), .CAP_NORM_0(3'd5), .CAP_1(3'd7), .ALT_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .id_submit(id_submit), .MODE(MODE), .chosen_flr(chosen_flr),
    .alt_accept(alt_accept), .alt_decline(alt_decline), .id_valid(id_valid),
    .id_special(id_special), .adminId_valid(adminId_valid), .id_exists(id_exists),
    .id_restricted(id_restricted), .user_flr(user_flr), .action_taken(action_taken),
    .remain_flr_spec_0(remain_flr_spec_0), .remain_flr_norm_0(remain_flr_norm_0),
    .remain_flr_1(remain_flr_1), .status(status), .busy(busy));

  always #5 CLK = ~CLK;

  // act: nonzero action seen, ncyc: cycles it was nonzero, st: final status, then counters
  typedef struct packed {
    logic [2:0] act, ncyc, st, s0, n0, f1;
  } res_t;

  res_t exp_q[$];
  int   checks = 0, errors = 0;
  int   m_s0 = 2, m_n0 = 5, m_f1 = 7;

  function automatic res_t mk(input int act, input int n, input int st);
    mk = '{3'(act), 3'(n), 3'(st), 3'(m_s0), 3'(m_n0), 3'(m_f1)};
  endfunction

  // reply: 0 none, 1 accept, 2 decline, 3 both (alt); any nonzero sends the admin target submit
  task automatic txn(input logic [1:0] md, input logic flr, input logic sp, input logic vl,
                     input logic adm, input logic ex, input logic uf, input int reply,
                     output res_t r, output int wait_cyc);
    logic [2:0] act = '0;
    int ncyc = 0;
    bit replied = 0, done = 0;
    wait_cyc = 0;
    MODE = md; chosen_flr = flr; id_special = sp; id_valid = vl;
    adminId_valid = adm; id_exists = ex; user_flr = uf;
    @(negedge CLK); id_submit = 1'b1;
    @(negedge CLK); id_submit = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!busy) begin done = 1; break; end
      if (action_taken != '0) begin act = action_taken; ncyc++; end
      if (status == 3'd3 || status == 3'd6) wait_cyc++;
      if (!replied && reply != 0 && status == 3'd3) begin
        alt_accept = reply[0]; alt_decline = reply[1]; replied = 1;
      end
      if (!replied && reply != 0 && status == 3'd6) begin
        id_submit = 1'b1; replied = 1;
      end
      @(negedge CLK);
      alt_accept = 1'b0; alt_decline = 1'b0; id_submit = 1'b0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: busy still %b after 80 cycles, required 0", busy);
    end
    r = '{act, 3'(ncyc), status, remain_flr_spec_0, remain_flr_norm_0, remain_flr_1};
  endtask

  task automatic test_reset;
    RST = 1'b1; m_s0 = 2; m_n0 = 5; m_f1 = 7;
    repeat (2) @(negedge CLK);
    RST = 1'b0; #1;
    checks++; if (status !== 3'd0) begin errors++; $display("FAIL reset_status: got %0d required 0", status); end
    checks++; if (action_taken !== 3'd0) begin errors++; $display("FAIL reset_action: got %0d required 0", action_taken); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== {3'd2, 3'd5, 3'd7}) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d required 2/5/7",
                         remain_flr_spec_0, remain_flr_norm_0, remain_flr_1);
    end
  endtask

  task automatic test_enter_normal;
    res_t got, e; int w;
    m_f1--; exp_q.push_back(mk(2, 1, 1));
    txn(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL enter_f1: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL enter_invalid: got %h required %h", got, e); end
  endtask

  task automatic test_alt_floor;
    res_t got, e; int w;
    for (int i = 0; i < 5; i++) begin
      m_n0--; exp_q.push_back(mk(2, 1, 1));
      txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL fill_f0[%0d]: got %h required %h", i, got, e); end
    end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL alt_decline: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL alt_timeout: got %h required %h", got, e); end
    checks++;
    if (w !== 16) begin errors++; $display("FAIL alt_timeout_len: got %0d cycles required 16", w); end
    m_f1--; exp_q.push_back(mk(1, 1, 1));
    txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL alt_accept: got %h required %h", got, e); end
    m_f1--; exp_q.push_back(mk(1, 1, 1));
    txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL alt_both: got %h required %h", got, e); end
  endtask

  task automatic test_both_full;
    res_t got, e; int w;
    while (m_f1 > 0) begin
      m_f1--; exp_q.push_back(mk(2, 1, 1));
      txn(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL fill_f1: got %h required %h", got, e); end
    end
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(mk(0, 0, 4));
      txn(2'd0, 1'(f), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL both_full[%0d]: got %h required %h", f, got, e); end
    end
    m_f1++; exp_q.push_back(mk(3, 1, 1));
    txn(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL exit_f1: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL exit_invalid: got %h required %h", got, e); end
  endtask

  task automatic test_special;
    res_t got, e; int w;
    for (int i = 0; i < 3; i++) begin
      if (m_s0 > 0) begin m_s0--; exp_q.push_back(mk(2, 1, 1)); end
      else exp_q.push_back(mk(0, 0, 4));
      txn(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL special_enter[%0d]: got %h required %h", i, got, e); end
    end
    m_s0++; exp_q.push_back(mk(3, 1, 1));
    txn(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL special_exit: got %h required %h", got, e); end
  endtask

  task automatic test_admin;
    res_t got, e; int w;
    exp_q.push_back(mk(4, 1, 5));
    txn(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL admin_restrict: got %h required %h", got, e); end
    exp_q.push_back(mk(5, 1, 5));
    txn(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL admin_unrestrict: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL admin_nonadmin: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL admin_no_target: got %h required %h", got, e); end
    exp_q.push_back(mk(0, 0, 2));
    txn(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, got, w);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL admin_timeout: got %h required %h", got, e); end
    checks++;
    if (w !== 16) begin errors++; $display("FAIL admin_timeout_len: got %0d cycles required 16", w); end
  endtask

  task automatic test_exit_saturate;
    res_t got, e; int w;
    test_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(3, 1, 1));
      txn(2'd1, 1'b0, 1'(k == 0), 1'b1, 1'b0, 1'b0, 1'(k == 2), 0, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL exit_saturate[%0d]: got %h required %h", k, got, e); end
    end
  endtask

  task automatic test_rst_in_alt_wait;
    res_t got, e; int w;
    bit seen = 0;
    for (int i = 0; i < 5; i++) begin
      m_n0--; exp_q.push_back(mk(2, 1, 1));
      txn(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, got, w);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL refill_f0[%0d]: got %h required %h", i, got, e); end
    end
    MODE = 2'd0; chosen_flr = 1'b0; id_special = 1'b0; id_valid = 1'b1;
    @(negedge CLK); id_submit = 1'b1;
    @(negedge CLK); id_submit = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (status == 3'd3) seen = 1; else @(negedge CLK);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_alt_enter: status %0d required 3", status); end
    @(negedge CLK); RST = 1'b1; #1;
    m_s0 = 2; m_n0 = 5; m_f1 = 7;
    checks++;
    if ({busy, action_taken, status} !== {1'b0, 3'd0, 3'd0}) begin
      errors++; $display("FAIL rst_alt_state: busy/act/status %b/%0d/%0d required 0/0/0", busy, action_taken, status);
    end
    checks++;
    if ({remain_flr_spec_0, remain_flr_norm_0, remain_flr_1} !== {3'd2, 3'd5, 3'd7}) begin
      errors++; $display("FAIL rst_alt_counters: got %0d/%0d/%0d required 2/5/7",
                         remain_flr_spec_0, remain_flr_norm_0, remain_flr_1);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_enter_normal();
    test_alt_floor();
    test_both_full();
    test_special();
    test_admin();
    test_exit_saturate();
    test_rst_in_alt_wait();
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
